// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller and its bench.
package run_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} run_state_t;

  localparam int unsigned START_CYCLES_DEF = 2;
  localparam int unsigned MAX_CYCLES_DEF   = 50000;
  localparam int unsigned CT_W_DEF         = 16;

endpackage

// File: rtl/sat_cycle_counter.sv
// Up-counter with synchronous clear that stops once it reaches the limit value.
module sat_cycle_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_q, count_d;

  assign at_limit = (count_q == limit);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in init, releases it, and times the run
// until halt or timeout, reporting a latched count and a done pulse.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned START_CYCLES = START_CYCLES_DEF,
  parameter int unsigned CT_W         = CT_W_DEF,
  parameter int unsigned MAX_CYCLES   = MAX_CYCLES_DEF
) (
  input  logic            CLK,
  input  logic            start,
  input  logic            go,
  input  logic            dut_halt,
  output logic            dut_start,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CT_W-1:0] cycle_ct,
  output logic [7:0]      run_ct
);

  localparam int unsigned IW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  run_state_t      state_q, state_d;
  logic [IW-1:0]   init_q, init_d;
  logic            timeout_q, timeout_d;
  logic [CT_W-1:0] cycle_ct_q, cycle_ct_d;
  logic [7:0]      run_ct_q, run_ct_d;
  logic            dut_start_q, dut_start_d;

  logic            ctr_clear, ctr_en, at_limit;
  logic [CT_W-1:0] ctr_count;

  sat_cycle_counter #(
    .W (CT_W)
  ) u_run_ctr (
    .clk      (CLK),
    .rst      (start),
    .clear    (ctr_clear),
    .enable   (ctr_en),
    .limit    (CT_W'(MAX_CYCLES - 1)),
    .count    (ctr_count),
    .at_limit (at_limit)
  );

  // Results and run_ct are latched on the RUN->FIN edge so they are already
  // valid while done is high.
  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    timeout_d  = timeout_q;
    cycle_ct_d = cycle_ct_q;
    run_ct_d   = run_ct_q;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          init_d    = IW'(START_CYCLES - 1);
          timeout_d = 1'b0;
          state_d   = INIT;
        end
      end
      INIT: begin
        if (init_q == '0) begin
          ctr_clear = 1'b1;
          state_d   = RUN;
        end else begin
          init_d = init_q - IW'(1);
        end
      end
      RUN: begin
        if (dut_halt) begin
          cycle_ct_d = ctr_count;
          run_ct_d   = run_ct_q + 8'd1;
          state_d    = FIN;
        end else if (at_limit) begin
          cycle_ct_d = CT_W'(MAX_CYCLES);
          timeout_d  = 1'b1;
          run_ct_d   = run_ct_q + 8'd1;
          state_d    = FIN;
        end else begin
          ctr_en = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dut_start_d = (state_d != RUN);
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q     <= IDLE;
      init_q      <= '0;
      timeout_q   <= 1'b0;
      cycle_ct_q  <= '0;
      run_ct_q    <= '0;
      dut_start_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      timeout_q   <= timeout_d;
      cycle_ct_q  <= cycle_ct_d;
      run_ct_q    <= run_ct_d;
      dut_start_q <= dut_start_d;
    end
  end

  assign dut_start = dut_start_q;
  assign busy      = (state_q == INIT) || (state_q == RUN);
  assign done      = (state_q == FIN);
  assign timeout   = timeout_q;
  assign cycle_ct  = cycle_ct_q;
  assign run_ct    = run_ct_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a run-level timing model.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int unsigned S    = START_CYCLES_DEF;
  localparam int unsigned MAXC = 20;

  logic        CLK = 1'b0;
  logic        start = 1'b1;
  logic        go = 1'b0;
  logic        dut_halt = 1'b0;
  logic        dut_start, busy, done, timeout;
  logic [15:0] cycle_ct;
  logic [7:0]  run_ct;

  int checks = 0;
  int errors = 0;

  run_ctrl #(
    .START_CYCLES (S),
    .CT_W         (16),
    .MAX_CYCLES   (MAXC)
  ) dut (
    .CLK       (CLK),
    .start     (start),
    .go        (go),
    .dut_halt  (dut_halt),
    .dut_start (dut_start),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycle_ct  (cycle_ct),
    .run_ct    (run_ct)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by its age in cycles since go was accepted.
  // Ages 1..S are init; from S+1 on the core runs and age-S-1 is the number of
  // halt-free run cycles seen so far.
  bit m_valid = 0, m_active = 0, m_fin = 0, m_to = 0;
  int m_age = 0, m_cycle = 0, m_runs = 0;

  always @(posedge CLK) begin
    if (start) begin
      m_valid = 1; m_active = 0; m_fin = 0; m_to = 0;
      m_age = 0; m_cycle = 0; m_runs = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (go) begin
        m_active = 1; m_age = 1; m_to = 0;
      end
    end else if (m_age <= int'(S)) begin
      m_age++;
    end else begin
      int n;
      n = m_age - int'(S) - 1;
      if (dut_halt) begin
        m_cycle = n; m_fin = 1; m_active = 0; m_runs++;
      end else if (n == int'(MAXC) - 1) begin
        m_cycle = MAXC; m_to = 1; m_fin = 1; m_active = 0; m_runs++;
      end else begin
        m_age++;
      end
    end
    #1;
    if (m_valid) begin
      check("dut_start", dut_start, !(m_active && m_age > int'(S)));
      check("busy", busy, m_active);
      check("done", done, m_fin);
      check("timeout", timeout, m_to);
      check("cycle_ct", cycle_ct, m_cycle);
      check("run_ct", run_ct, m_runs % 256);
    end
  end

  task automatic wait_run();
    for (int i = 0; i < 50; i++) begin
      if (dut_start === 1'b0 && busy === 1'b1) return;
      @(negedge CLK);
    end
    check("run_entry_bound", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < int'(MAXC) + 40; i++) begin
      if (done === 1'b1) return;
      @(negedge CLK);
    end
    check("done_bound", 0, 1);
  endtask

  task automatic halt_after(input int k);
    wait_run();
    repeat (k) @(negedge CLK);
    dut_halt = 1'b1;
    @(negedge CLK);
    dut_halt = 1'b0;
    wait_done();
  endtask

  initial begin
    int hp;
    repeat (2) @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    check("idle_dut_start", dut_start, 1);
    check("idle_busy", busy, 0);
    check("idle_run_ct", run_ct, 0);
    check("idle_cycle_ct", cycle_ct, 0);

    // halt after 10 run cycles, with a go pulse during RUN that must be ignored
    go = 1'b1; @(negedge CLK); go = 1'b0;
    wait_run();
    repeat (3) @(negedge CLK);
    go = 1'b1; @(negedge CLK); go = 1'b0;
    repeat (6) @(negedge CLK);
    dut_halt = 1'b1; @(negedge CLK); dut_halt = 1'b0;
    wait_done();
    check("halt10_cycle_ct", cycle_ct, 10);
    check("halt10_timeout", timeout, 0);
    check("halt10_run_ct", run_ct, 1);

    // no halt: timeout at MAXC
    @(negedge CLK);
    go = 1'b1; @(negedge CLK); go = 1'b0;
    wait_done();
    check("to_cycle_ct", cycle_ct, MAXC);
    check("to_timeout", timeout, 1);
    check("to_run_ct", run_ct, 2);

    // halt held through IDLE, INIT and first RUN cycle
    @(negedge CLK);
    dut_halt = 1'b1;
    @(negedge CLK);
    check("to_sticky_idle", timeout, 1);
    go = 1'b1; @(negedge CLK); go = 1'b0;
    check("to_cleared", timeout, 0);
    check("halt_in_init_busy", busy, 1);
    wait_done();
    dut_halt = 1'b0;
    check("early_halt_cycle_ct", cycle_ct, 0);
    check("early_halt_run_ct", run_ct, 3);
    repeat (3) @(negedge CLK);

    // back-to-back runs with go held high
    start = 1'b1; @(negedge CLK); start = 1'b0;
    go = 1'b1;
    halt_after(5);
    check("b2b_1_cycle_ct", cycle_ct, 5);
    halt_after(7);
    check("b2b_2_cycle_ct", cycle_ct, 7);
    halt_after(3);
    go = 1'b0;
    check("b2b_run_ct", run_ct, 3);
    check("b2b_cycle_ct", cycle_ct, 3);
    repeat (3) @(negedge CLK);

    // reset in the middle of a run
    start = 1'b1; @(negedge CLK); start = 1'b0;
    go = 1'b1; @(negedge CLK); go = 1'b0;
    wait_run();
    repeat (4) @(negedge CLK);
    start = 1'b1; @(negedge CLK); start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_dut_start", dut_start, 1);
    check("rst_run_ct", run_ct, 0);
    check("rst_cycle_ct", cycle_ct, 0);
    repeat (5) @(negedge CLK);

    // randomized traffic with varying halt density
    hp = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: hp = 0;
          1: hp = 3;
          2: hp = 15;
          default: hp = 50;
        endcase
      end
      start    = ($urandom_range(0, 299) == 0);
      go       = ($urandom_range(0, 3) == 0);
      dut_halt = ($urandom_range(0, 99) < hp);
      @(negedge CLK);
    end
    start = 1'b0; go = 1'b0; dut_halt = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sits directly upstream of the processor top level and drives its `start` input. It accepts a run request, holds the core in init for a fixed number of cycles, releases it, and counts cycles until the core raises `halt` or a timeout expires. It then reports a latched cycle count, a one-cycle done pulse and a sticky timeout flag to the bench or host.

## Interface
- `START_CYCLES`, default 2: cycles `dut_start` is held high after a request (≥1).
- `CT_W`, default 16: width of the cycle counter and `cycle_ct`.
- `MAX_CYCLES`, default 16'd50000: RUN-cycle limit before timeout (≤ 2^CT_W − 1).
- `CLK`  in  1  clock; all logic on posedge.
- `start`  in  1  reset; synchronous, active-high.
- `go`  in  1  run request; sampled only in IDLE.
- `dut_halt`  in  1  core's `halt` output.
- `dut_start`  out  1  to core's `start`; registered.
- `busy`  out  1  high in INIT and RUN.
- `done`  out  1  one-cycle pulse when a run ends (halt or timeout).
- `timeout`  out  1  sticky; set when a run ends by timeout.
- `cycle_ct`  out  CT_W  latched RUN-cycle count of the last finished run.
- `run_ct`  out  8  number of finished runs; wraps 255→0.

## Operation
- States: IDLE, INIT, RUN, FIN.
- IDLE: `dut_start`=1, so the core is held in init. If `go`=1, load init counter with START_CYCLES−1, clear `timeout`, and go to INIT.
- INIT: `dut_start`=1. Decrement the init counter. At 0, clear the cycle counter and go to RUN.
- RUN: `dut_start`=0.
  - `dut_halt`=1: latch the counter into `cycle_ct` and go to FIN.
  - Else, if counter == MAX_CYCLES−1: latch MAX_CYCLES, set `timeout`, and go to FIN.
  - Else: increment the counter.
- FIN: `done`=1 for exactly this cycle, `run_ct` += 1, `dut_start`=1, then return to IDLE.
- `dut_halt` is ignored outside RUN. A core asserting halt while in init has no effect.
- `go` is ignored in INIT, RUN and FIN; there is no queuing. If `go` is held high, a new run starts the cycle after FIN.
- `cycle_ct` = number of RUN cycles in which `dut_halt` was sampled 0. If halt is seen in the first RUN cycle, the result is 0.
- Halt and limit in the same cycle: halt wins; `timeout` stays 0.
- `cycle_ct` and `run_ct` hold their values across runs until overwritten. Arithmetic is unsigned. The counter never wraps, because the limit is checked first.

## Timing
- Reset values:
  - state = IDLE
  - `dut_start`=1
  - `busy`=0, `done`=0, `timeout`=0
  - `cycle_ct`=0, `run_ct`=0
- Reset is synchronous and takes priority over everything. Reset mid-run returns to IDLE on the next edge, discards the partial count, and does not produce a `done` pulse.
- `go` sampled at edge t: INIT occupies cycles t+1 … t+START_CYCLES; `dut_start` falls at t+START_CYCLES+1 (first RUN cycle).
- Halt sampled at RUN edge h: FIN (`done`=1, `cycle_ct` valid) in cycle h+1; IDLE in h+2.
- All outputs are registered or decoded from state only; none depends combinationally on inputs.

## Structure
- Package `run_ctrl_pkg`: `typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} run_state_t;` plus the default START_CYCLES / MAX_CYCLES constants shared with the bench.
- One sub-module, `sat_cycle_counter`:
  - Ports: clear, enable, limit compare, `at_limit` flag.
  - Instantiated for the RUN counter.
  - The init counter stays inline.

## Test plan
- Reset, then idle 5 cycles: `dut_start`=1, `busy`=0, `done`=0, `cycle_ct`=0, `run_ct`=0 throughout.
- `go` pulse; model raises `dut_halt` after 10 RUN cycles. Expect:
  - `dut_start` high for 2 cycles, then low.
  - `done` pulses once with `cycle_ct`=10, `timeout`=0, `run_ct`=1.
- MAX_CYCLES=20, `dut_halt` never rises: `done` pulses after 20 RUN cycles; `timeout`=1, `cycle_ct`=20. `timeout` clears on the next `go`.
- `dut_halt`=1 during IDLE/INIT and in the first RUN cycle: no early exit; `cycle_ct`=0.
- `go` held high for 3 back-to-back runs with halts at 5, 7 and 3: three `done` pulses, final `run_ct`=3, `cycle_ct`=3. A `go` pulse during RUN is ignored.
- Assert `start` mid-RUN: next cycle state is IDLE, `done` never pulses, and `run_ct`/`cycle_ct` are 0.
